// File: rtl/uart_tx_drain.sv
// rtl/uart_tx_drain.sv - FIFO-draining 8N1 UART transmitter (optional even parity via UART_TX_PARITY_EN)
module uart_tx_drain #(
    parameter int WD           = 32,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_en,
    input  logic [WD-1:0] i_fifo_data,
    input  logic          i_fifo_empty,
    output logic          o_fifo_rd,
    output logic          o_tx,
    output logic          o_busy,
    output logic          o_done
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_d, rd_d, busy_d, done_d;
    logic          bit_end;

    // Upper FIFO word bits are never transmitted.
    logic          unused_hi;
    assign unused_hi = ^i_fifo_data[WD-1:8];

`ifdef UART_TX_PARITY_EN
    logic          par_q, par_d;

    // Parity of the captured byte, fixed for the whole frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) par_q <= 1'b0;
        else          par_q <= par_d;
    end
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    // State, datapath and registered outputs; reset forces the line idle at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            o_tx      <= 1'b1;
            o_fifo_rd <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            o_tx      <= tx_d;
            o_fifo_rd <= rd_d;
            o_busy    <= busy_d;
            o_done    <= done_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they register in step with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_en && !i_fifo_empty) begin
                    state_d = S_START;
                    shift_d = i_fifo_data[7:0];
`ifdef UART_TX_PARITY_EN
                    par_d   = ^i_fifo_data[7:0];
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    cnt_d   = '0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        rd_d   = (state_q == S_IDLE) && (state_d == S_START);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (cnt_d == CNT_LAST);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_drain.sv
// tb/tb_uart_tx_drain.sv - directed self-checking bench for uart_tx_drain
module tb_uart_tx_drain;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FC = CPB * NB;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_rd;
    logic        tx;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:15];
    int          rd_ptr = 0;
    int          wr_ptr = 0;
    int          pops   = 0;

    logic        tx_s [0:127];
    logic        rd_s [0:127];
    logic        dn_s [0:127];

    int          errs = 0;
    int          nchk = 0;

    uart_tx_drain #(.WD(32), .CLKS_PER_BIT(CPB)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_fifo_data  (fifo_data),
        .i_fifo_empty (fifo_empty),
        .o_fifo_rd    (fifo_rd),
        .o_tx         (tx),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_data  = mem[rd_ptr[3:0]];
    assign fifo_empty = (rd_ptr == wr_ptr);

    // First-word-fall-through FIFO model: pops on the edge that ends an o_fifo_rd cycle.
    always @(posedge clk) begin
        if (fifo_rd && (rd_ptr != wr_ptr)) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    task automatic push(input logic [31:0] w);
        mem[wr_ptr[3:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int s, input int n);
        for (int i = 0; i < n; i++) begin
            tx_s[s+i] = tx;
            rd_s[s+i] = fifo_rd;
            dn_s[s+i] = done;
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] decode(input int s);
        logic [7:0] d;
        for (int i = 0; i < 8; i++) d[i] = tx_s[s + CPB*(i+1) + 2];
        return d;
    endfunction

    function automatic int count_rd(input int s, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(rd_s[s+i]);
        return c;
    endfunction

    function automatic int count_dn(input int s, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(dn_s[s+i]);
        return c;
    endfunction

    function automatic logic all_high(input int s, input int n);
        logic ok = 1'b1;
        for (int i = 0; i < n; i++) ok = ok & tx_s[s+i];
        return ok;
    endfunction

    function automatic logic exp_bit(input logic [7:0] d, input int p);
        if (p == 0) return 1'b0;
        if (p <= 8) return d[p-1];
        if (NB == 11 && p == 9) return ^d;
        return 1'b1;
    endfunction

    initial begin
        logic [3:0] got;
        rst_n = 1'b0;
        en    = 1'b1;
        push(32'h0000_00A5);
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_rd", fifo_rd, 0);
        check("rst_done", done, 0);
        check("rst_pops", pops, 0);

        // Release: frame 0xA5 starts on the next edge.
        rst_n = 1'b1;
        @(negedge clk);
        sample(0, FC + 1);
        for (int p = 0; p < NB; p++) begin
            got = {tx_s[CPB*p], tx_s[CPB*p+1], tx_s[CPB*p+2], tx_s[CPB*p+3]};
            check($sformatf("a5_bit%0d", p), got, {4{exp_bit(8'hA5, p)}});
        end
        check("a5_rd_first", rd_s[0], 1);
        check("a5_rd_count", count_rd(0, FC + 1), 1);
        check("a5_done_last", dn_s[FC-1], 1);
        check("a5_done_count", count_dn(0, FC + 1), 1);
        check("a5_idle_tx", tx_s[FC], 1);
        check("a5_pops", pops, 1);
        check("a5_busy_after", busy, 0);

        // Back-to-back frames.
        push(32'hDEAD_BE55);
        push(32'h0000_000F);
        @(negedge clk);
        sample(0, 2*FC + 1);
        check("b2b_byte0", decode(0), 8'h55);
        check("b2b_byte1", decode(FC + 1), 8'h0F);
        check("b2b_last_low", tx_s[FC-5], 0);
        check("b2b_gap_high", all_high(FC - CPB, CPB + 1), 1);
        check("b2b_start2", tx_s[FC+1], 0);
        check("b2b_rd_second", rd_s[FC+1], 1);
        check("b2b_rd_count", count_rd(0, 2*FC + 1), 2);
        check("b2b_done_count", count_dn(0, 2*FC + 1), 2);
        check("b2b_pops", pops, 3);

        // Enable dropped mid-frame.
        push(32'h0000_00FF);
        push(32'h0000_003C);
        @(negedge clk);
        sample(0, 12);
        en = 1'b0;
        sample(12, FC + 20);
        check("en_byte", decode(0), 8'hFF);
        check("en_done", dn_s[FC-1], 1);
        check("en_line_high", all_high(FC - CPB, CPB + 32), 1);
        check("en_rd_count", count_rd(0, FC + 32), 1);
        check("en_pops", pops, 4);
        check("en_busy", busy, 0);
        en = 1'b1;
        @(negedge clk);
        sample(0, FC + 1);
        check("en_resume_tx", tx_s[0], 0);
        check("en_resume_rd", rd_s[0], 1);
        check("en_resume_byte", decode(0), 8'h3C);
        check("en_resume_pops", pops, 5);

        // Reset in the middle of data bit 3.
        push(32'h0000_0096);
        push(32'h0000_0069);
        @(negedge clk);
        sample(0, 18);
        check("mid_bit3", tx, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_rd", fifo_rd, 0);
        repeat (2) @(negedge clk);
        check("abort_pops", pops, 6);
        rst_n = 1'b1;
        @(negedge clk);
        sample(0, FC + 1);
        check("restart_rd", rd_s[0], 1);
        check("restart_rd_count", count_rd(0, FC + 1), 1);
        check("restart_byte", decode(0), 8'h69);
        check("restart_pops", pops, 7);

`ifdef UART_TX_PARITY_EN
        push(32'h0000_0007);
        push(32'h0000_0003);
        @(negedge clk);
        sample(0, 2*FC + 1);
        check("par_07", tx_s[CPB*9 + 2], 1);
        check("par_03", tx_s[FC + 1 + CPB*9 + 2], 0);
        check("par_len", dn_s[43], 1);
        check("par_pops", pops, 9);
`endif

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
